// File: rtl/alu_pkg.sv
// Shared ALU definitions: op-code map and the multiply/divide sequencer state encoding.
package alu_pkg;

    localparam logic [3:0] OP_ADD = 4'b0000;
    localparam logic [3:0] OP_SUB = 4'b0001;
    localparam logic [3:0] OP_MUL = 4'b0010;
    localparam logic [3:0] OP_DIV = 4'b0011;
    localparam logic [3:0] OP_SHR = 4'b0100;
    localparam logic [3:0] OP_SHL = 4'b0101;
    localparam logic [3:0] OP_ROR = 4'b0110;
    localparam logic [3:0] OP_ROL = 4'b0111;
    localparam logic [3:0] OP_AND = 4'b1000;
    localparam logic [3:0] OP_OR  = 4'b1001;
    localparam logic [3:0] OP_NEG = 4'b1010;
    localparam logic [3:0] OP_NOT = 4'b1011;

    typedef enum logic [2:0] {
        ST_IDLE,
        ST_MUL,
        ST_DIV,
        ST_FIX,
        ST_DONE
    } mds_state_e;

endpackage

// File: rtl/alu_muldiv_seq.sv
// Iterative signed multiply (radix-2 Booth) and signed divide (restoring on magnitudes)
// sharing one WIDTH+1 bit adder/subtractor; results land in ZHI/ZLO on entry to DONE.
module alu_muldiv_seq
    import alu_pkg::*;
#(
    parameter int WIDTH = 32,
    parameter int CNT_W = 6
) (
    input  logic             clk,
    input  logic             clr,
    input  logic             start,
    input  logic [3:0]       ctrl,
    input  logic [WIDTH-1:0] A,
    input  logic [WIDTH-1:0] B,
    output logic             busy,
    output logic             done,
    output logic             div0,
    output logic             illegal,
    output logic [WIDTH-1:0] ZHI,
    output logic [WIDTH-1:0] ZLO
);

    localparam logic [CNT_W-1:0] LAST = CNT_W'(WIDTH - 1);

    mds_state_e       state_q, state_d;
    logic [CNT_W-1:0] cnt_q, cnt_d;
    logic [WIDTH:0]   hi_q, hi_d;     // Booth P_hi (sign-extended) or remainder
    logic [WIDTH-1:0] lo_q, lo_d;     // Booth P_lo or quotient
    logic             qm1_q, qm1_d;
    logic [WIDTH:0]   opnd_q, opnd_d; // sign-extended multiplicand or |divisor|
    logic             negq_q, negq_d;
    logic             negr_q, negr_d;
    logic [WIDTH-1:0] zhi_q, zhi_d;
    logic [WIDTH-1:0] zlo_q, zlo_d;
    logic             div0_q, div0_d;
    logic             ill_q, ill_d;
    logic             done_q, done_d;

    logic [WIDTH:0]   add_a, add_b, sum;
    logic             add_sub;
    logic [WIDTH:0]   booth_hi;
    logic [WIDTH-1:0] abs_a, abs_b;

    assign abs_a = A[WIDTH-1] ? (WIDTH'(0) - A) : A;
    assign abs_b = B[WIDTH-1] ? (WIDTH'(0) - B) : B;

    // One adder serves both paths: Booth add/sub of A, or restoring trial subtract of |B|.
    always_comb begin
        add_a   = hi_q;
        add_b   = opnd_q;
        add_sub = lo_q[0];
        if (state_q == ST_DIV) begin
            add_a   = {hi_q[WIDTH-1:0], lo_q[WIDTH-1]};
            add_sub = 1'b1;
        end
        sum      = add_sub ? (add_a - add_b) : (add_a + add_b);
        booth_hi = (lo_q[0] ^ qm1_q) ? sum : hi_q;
    end

    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        hi_d    = hi_q;
        lo_d    = lo_q;
        qm1_d   = qm1_q;
        opnd_d  = opnd_q;
        negq_d  = negq_q;
        negr_d  = negr_q;
        zhi_d   = zhi_q;
        zlo_d   = zlo_q;
        div0_d  = div0_q;
        ill_d   = ill_q;
        done_d  = (state_q == ST_DONE);

        case (state_q)
            ST_IDLE: begin
                if (start) begin
                    cnt_d  = '0;
                    div0_d = 1'b0;
                    ill_d  = 1'b0;
                    qm1_d  = 1'b0;
                    hi_d   = '0;
                    negq_d = A[WIDTH-1] ^ B[WIDTH-1];
                    negr_d = A[WIDTH-1];
                    case (ctrl)
                        OP_MUL: begin
                            lo_d    = B;
                            opnd_d  = {A[WIDTH-1], A};
                            state_d = ST_MUL;
                        end
                        OP_DIV: begin
                            if (B == '0) begin
                                div0_d  = 1'b1;
                                zlo_d   = '1;
                                zhi_d   = A;
                                state_d = ST_DONE;
                            end else begin
                                lo_d    = abs_a;
                                opnd_d  = {1'b0, abs_b};
                                state_d = ST_DIV;
                            end
                        end
                        default: begin
                            ill_d   = 1'b1;
                            zhi_d   = '0;
                            zlo_d   = '0;
                            state_d = ST_DONE;
                        end
                    endcase
                end
            end
            ST_MUL: begin
                hi_d  = {booth_hi[WIDTH], booth_hi[WIDTH:1]};
                lo_d  = {booth_hi[0], lo_q[WIDTH-1:1]};
                qm1_d = lo_q[0];
                cnt_d = cnt_q + 1'b1;
                if (cnt_q == LAST) begin
                    zhi_d   = hi_d[WIDTH-1:0];
                    zlo_d   = lo_d;
                    state_d = ST_DONE;
                end
            end
            ST_DIV: begin
                // Non-negative trial (sign bit clear) keeps the subtraction.
                hi_d  = sum[WIDTH] ? add_a : sum;
                lo_d  = {lo_q[WIDTH-2:0], ~sum[WIDTH]};
                cnt_d = cnt_q + 1'b1;
                if (cnt_q == LAST) begin
                    state_d = ST_FIX;
                end
            end
            ST_FIX: begin
                zlo_d   = negq_q ? (WIDTH'(0) - lo_q) : lo_q;
                zhi_d   = negr_q ? (WIDTH'(0) - hi_q[WIDTH-1:0]) : hi_q[WIDTH-1:0];
                state_d = ST_DONE;
            end
            ST_DONE: begin
                state_d = ST_IDLE;
            end
            default: begin
                state_d = ST_IDLE;
            end
        endcase
    end

    always_ff @(posedge clk or negedge clr) begin
        if (!clr) begin
            state_q <= ST_IDLE;
            cnt_q   <= '0;
            hi_q    <= '0;
            lo_q    <= '0;
            qm1_q   <= 1'b0;
            opnd_q  <= '0;
            negq_q  <= 1'b0;
            negr_q  <= 1'b0;
            zhi_q   <= '0;
            zlo_q   <= '0;
            div0_q  <= 1'b0;
            ill_q   <= 1'b0;
            done_q  <= 1'b0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            hi_q    <= hi_d;
            lo_q    <= lo_d;
            qm1_q   <= qm1_d;
            opnd_q  <= opnd_d;
            negq_q  <= negq_d;
            negr_q  <= negr_d;
            zhi_q   <= zhi_d;
            zlo_q   <= zlo_d;
            div0_q  <= div0_d;
            ill_q   <= ill_d;
            done_q  <= done_d;
        end
    end

    assign busy    = (state_q == ST_MUL) || (state_q == ST_DIV) || (state_q == ST_FIX);
    assign done    = done_q;
    assign div0    = div0_q;
    assign illegal = ill_q;
    assign ZHI     = zhi_q;
    assign ZLO     = zlo_q;

endmodule

// File: tb/tb_alu_muldiv_seq.sv
// Scoreboard bench for alu_muldiv_seq: driver pushes model results, monitor checks on done.
module tb_alu_muldiv_seq;
    import alu_pkg::*;

    localparam int W = 32;

    logic         clk = 1'b0;
    logic         clr = 1'b0;
    logic         start = 1'b0;
    logic [3:0]   ctrl = 4'b0;
    logic [W-1:0] A = '0;
    logic [W-1:0] B = '0;
    logic         busy, done, div0, illegal;
    logic [W-1:0] ZHI, ZLO;

    alu_muldiv_seq #(.WIDTH(W), .CNT_W(6)) dut (
        .clk(clk), .clr(clr), .start(start), .ctrl(ctrl), .A(A), .B(B),
        .busy(busy), .done(done), .div0(div0), .illegal(illegal), .ZHI(ZHI), .ZLO(ZLO)
    );

    always #5 clk = ~clk;

    int cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    typedef struct {
        logic [W-1:0] zhi;
        logic [W-1:0] zlo;
        logic         d0;
        logic         il;
        int           t0;
        int           lat;
        int           nbusy;
    } exp_t;

    exp_t sbq[$];
    int   n_chk = 0;
    int   n_fail = 0;

    task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
        n_chk++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h", nm, act, exp);
        end
    endtask

    // Reference: plain signed arithmetic on 64-bit integers.
    function automatic exp_t model(input logic [3:0] op, input logic [W-1:0] a, input logic [W-1:0] b);
        exp_t   e;
        longint sa, sb, r, q;
        sa = longint'($signed(a));
        sb = longint'($signed(b));
        e.d0 = 1'b0; e.il = 1'b0; e.t0 = 0;
        e.zhi = '0; e.zlo = '0; e.lat = 1; e.nbusy = 0;
        if (op == OP_MUL) begin
            r = sa * sb;
            e.zhi = r[63:32]; e.zlo = r[31:0];
            e.lat = W + 1; e.nbusy = W;
        end else if (op == OP_DIV) begin
            if (b == '0) begin
                e.d0 = 1'b1; e.zlo = '1; e.zhi = a;
            end else begin
                q = sa / sb;
                r = sa % sb;
                e.zlo = q[31:0]; e.zhi = r[31:0];
                e.lat = W + 2; e.nbusy = W + 1;
            end
        end else begin
            e.il = 1'b1;
        end
        return e;
    endfunction

    always @(negedge clk) begin
        if (clr && done) begin
            if (sbq.size() == 0) begin
                n_chk++; n_fail++;
                $display("FAIL unexpected_done: got done with empty scoreboard expected none");
            end else begin
                exp_t e;
                e = sbq.pop_front();
                chk("zhi", 64'(ZHI), 64'(e.zhi));
                chk("zlo", 64'(ZLO), 64'(e.zlo));
                chk("div0", 64'(div0), 64'(e.d0));
                chk("illegal", 64'(illegal), 64'(e.il));
                chk("latency", 64'(cyc - e.t0), 64'(e.lat));
            end
        end
    end

    task automatic run_op(input logic [3:0] op, input logic [W-1:0] a, input logic [W-1:0] b,
                          input bit inject);
        exp_t e;
        int   k, nb;
        @(negedge clk);
        ctrl = op; A = a; B = b; start = 1'b1;
        e = model(op, a, b);
        e.t0 = cyc + 1;
        sbq.push_back(e);
        @(negedge clk);
        start = 1'b0;
        A = $urandom; B = $urandom; ctrl = 4'($urandom);
        k = 0; nb = 0;
        while (!done && k < 200) begin
            if (busy) nb++;
            start = inject && (k == 5);
            if (inject && k == 5) begin
                ctrl = OP_MUL; A = 32'd11; B = 32'd13;
            end
            @(negedge clk);
            k++;
        end
        start = 1'b0;
        if (!done) begin
            n_chk++; n_fail++;
            $display("FAIL timeout: got no done after %0d cycles expected done", k);
        end
        chk("busy_cycles", 64'(nb), 64'(e.nbusy));
        @(negedge clk);
        chk("done_pulse", 64'(done), 64'd0);
        chk("flag_hold", 64'({div0, illegal}), 64'({e.d0, e.il}));
    endtask

    logic [W-1:0] ra, rb;
    logic [3:0]   rop;
    int           sel;

    initial begin
        repeat (3) @(negedge clk);
        chk("rst_busy", 64'(busy), 64'd0);
        chk("rst_done", 64'(done), 64'd0);
        chk("rst_flags", 64'({div0, illegal}), 64'd0);
        chk("rst_zhi", 64'(ZHI), 64'd0);
        chk("rst_zlo", 64'(ZLO), 64'd0);
        clr = 1'b1;

        run_op(OP_MUL, 32'd7, 32'd6, 1'b0);
        run_op(OP_MUL, 32'h8000_0000, 32'hFFFF_FFFF, 1'b0);
        run_op(OP_MUL, -32'sd3, 32'd5, 1'b0);
        run_op(OP_MUL, 32'h8000_0000, 32'h8000_0000, 1'b0);
        run_op(OP_DIV, -32'sd7, 32'd2, 1'b0);
        run_op(OP_DIV, 32'd100, 32'd7, 1'b0);
        run_op(OP_DIV, 32'd5, 32'd0, 1'b0);
        run_op(OP_DIV, 32'h8000_0000, 32'hFFFF_FFFF, 1'b0);
        run_op(OP_DIV, 32'h8000_0000, 32'd1, 1'b0);
        run_op(OP_DIV, 32'd7, -32'sd2, 1'b0);
        run_op(OP_ADD, 32'd9, 32'd4, 1'b0);
        run_op(OP_MUL, 32'd1234, -32'sd77, 1'b1);

        // Reset in the middle of a divide: no result, everything back to zero.
        @(negedge clk);
        ctrl = OP_DIV; A = 32'd1000; B = 32'd3; start = 1'b1;
        @(negedge clk);
        start = 1'b0;
        repeat (9) @(negedge clk);
        clr = 1'b0;
        #1;
        chk("midrst_busy", 64'(busy), 64'd0);
        chk("midrst_done", 64'(done), 64'd0);
        chk("midrst_zhi", 64'(ZHI), 64'd0);
        chk("midrst_zlo", 64'(ZLO), 64'd0);
        chk("midrst_flags", 64'({div0, illegal}), 64'd0);
        @(negedge clk);
        clr = 1'b1;
        run_op(OP_MUL, 32'd3, 32'd3, 1'b0);

        for (int i = 0; i < 40; i++) begin
            sel = $urandom_range(0, 9);
            rop = (sel < 4) ? OP_MUL : (sel < 8) ? OP_DIV : 4'($urandom);
            ra = $urandom;
            rb = $urandom;
            sel = $urandom_range(0, 9);
            if (sel == 0) rb = '0;
            else if (sel == 1) rb = '1;
            else if (sel == 2) ra = 32'h8000_0000;
            else if (sel == 3) rb = 32'($urandom_range(1, 20));
            run_op(rop, ra, rb, (i % 7) == 3);
        end

        repeat (4) @(negedge clk);
        if (sbq.size() != 0) begin
            n_chk++; n_fail++;
            $display("FAIL leftover: got %0d pending results expected 0", sbq.size());
        end
        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end

endmodule
